// File: rtl/tc_to_binary_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tc_to_binary_pipe
// Brief    : Two-stage valid/ready thermometer-code to binary converter with
//            per-word illegal-code flag and saturating error counter.
//            Optional macro TC_BUBBLE_CORRECT_EN: illegal codes yield popcount.
// Revision : 1.0 - initial release
// ============================================================================
module tc_to_binary_pipe #(
    parameter int M   = 9,
    parameter int BW  = $clog2(M),
    parameter int ECW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [M-2:0]    in_tc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BW-1:0]   out_bin,
    output logic            out_err,
    output logic [ECW-1:0]  err_cnt,
    input  logic            clear_err
);

    localparam int             c_TW      = M - 1;
    localparam logic [ECW-1:0] c_CNT_MAX = {ECW{1'b1}};

    logic [c_TW:0]   w_tc_ext;
    logic [c_TW:0]   w_tc_plus1;
    logic            w_legal;
    logic [BW-1:0]   w_pop;
    logic [BW-1:0]   w_enc_bin;
    logic            w_b_free;
    logic            w_a_load;
    logic            w_err_xfer;

    logic            r_va;
    logic [BW-1:0]   r_a_bin;
    logic            r_a_err;
    logic            r_vb;
    logic [BW-1:0]   r_b_bin;
    logic            r_b_err;
    logic [ECW-1:0]  r_err_cnt;

    // A legal code 2^k-1 has no set bit in common with itself plus one.
    assign w_tc_ext   = {1'b0, in_tc};
    assign w_tc_plus1 = w_tc_ext + {{c_TW{1'b0}}, 1'b1};
    assign w_legal    = ((w_tc_ext & w_tc_plus1) == '0);

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_TW; i++) begin
            w_pop = w_pop + BW'(in_tc[i]);
        end
    end

`ifdef TC_BUBBLE_CORRECT_EN
    assign w_enc_bin = w_pop;
`else
    assign w_enc_bin = w_legal ? w_pop : '0;
`endif

    assign w_b_free   = !r_vb || out_ready;
    assign w_a_load   = !r_va || w_b_free;
    assign in_ready   = !rst && w_a_load;
    assign w_err_xfer = r_vb && out_ready && r_b_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_va    <= 1'b0;
            r_a_bin <= '0;
            r_a_err <= 1'b0;
            r_vb    <= 1'b0;
            r_b_bin <= '0;
            r_b_err <= 1'b0;
        end else begin
            if (w_a_load) begin
                r_va <= in_valid;
                if (in_valid) begin
                    r_a_bin <= w_enc_bin;
                    r_a_err <= !w_legal;
                end
            end
            // B only reloads when free, which holds its data stable under stall.
            if (w_b_free) begin
                r_vb <= r_va;
                if (r_va) begin
                    r_b_bin <= r_a_bin;
                    r_b_err <= r_a_err;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (clear_err) begin
            r_err_cnt <= w_err_xfer ? {{(ECW-1){1'b0}}, 1'b1} : '0;
        end else if (w_err_xfer && (r_err_cnt != c_CNT_MAX)) begin
            r_err_cnt <= r_err_cnt + {{(ECW-1){1'b0}}, 1'b1};
        end
    end

    assign out_valid = r_vb;
    assign out_bin   = r_b_bin;
    assign out_err   = r_b_err;
    assign err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tc_to_binary_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_tc_to_binary_pipe
// Brief    : Directed self-checking bench for tc_to_binary_pipe (M=9 and M=5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tc_to_binary_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // M=9 instance
    logic        v9 = 1'b0, rdy9, ov9, ordy9 = 1'b1, err9, clr9 = 1'b0;
    logic [7:0]  tc9 = 8'h00;
    logic [3:0]  bin9;
    logic [15:0] cnt9;

    // M=5 instance, narrow error counter
    logic        v5 = 1'b0, rdy5, ov5, ordy5 = 1'b1, err5, clr5 = 1'b0;
    logic [3:0]  tc5 = 4'h0;
    logic [2:0]  bin5;
    logic [3:0]  cnt5;

    int vectors = 0;
    int miscompares = 0;

`ifdef TC_BUBBLE_CORRECT_EN
    localparam logic [3:0] c_ILL9_BIN = 4'd2;
    localparam logic [2:0] c_ILL5_BIN = 3'd3;
`else
    localparam logic [3:0] c_ILL9_BIN = 4'd0;
    localparam logic [2:0] c_ILL5_BIN = 3'd0;
`endif

    tc_to_binary_pipe #(.M(9), .ECW(16)) u9 (
        .clk(clk), .rst(rst), .in_valid(v9), .in_ready(rdy9), .in_tc(tc9),
        .out_valid(ov9), .out_ready(ordy9), .out_bin(bin9), .out_err(err9),
        .err_cnt(cnt9), .clear_err(clr9)
    );

    tc_to_binary_pipe #(.M(5), .ECW(4)) u5 (
        .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_tc(tc5),
        .out_valid(ov5), .out_ready(ordy5), .out_bin(bin5), .out_err(err5),
        .err_cnt(cnt5), .clear_err(clr5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // reset behaviour
        step();
        chk("rst_in_ready", 32'(rdy9), 32'd0);
        step();
        chk("rst_out_valid", 32'(ov9), 32'd0);
        chk("rst_out_bin", 32'(bin9), 32'd0);
        chk("rst_out_err", 32'(err9), 32'd0);
        chk("rst_err_cnt", 32'(cnt9), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(rdy9), 32'd1);

        // legal stream, full throughput
        v9 = 1'b1; tc9 = 8'h00;
        step(); tc9 = 8'h01;
        step(); tc9 = 8'h07;
        chk("s1_valid0", 32'(ov9), 32'd1);
        chk("s1_bin0", 32'(bin9), 32'd0);
        chk("s1_err0", 32'(err9), 32'd0);
        step(); tc9 = 8'hFF;
        chk("s1_bin1", 32'(bin9), 32'd1);
        step(); v9 = 1'b0;
        chk("s1_bin3", 32'(bin9), 32'd3);
        step();
        chk("s1_bin8", 32'(bin9), 32'd8);
        chk("s1_err8", 32'(err9), 32'd0);
        step();
        chk("s1_drained", 32'(ov9), 32'd0);
        chk("s1_cnt", 32'(cnt9), 32'd0);

        // illegal bubble code
        v9 = 1'b1; tc9 = 8'b0000_0101;
        step(); v9 = 1'b0;
        step();
        chk("ill_valid", 32'(ov9), 32'd1);
        chk("ill_err", 32'(err9), 32'd1);
        chk("ill_bin", 32'(bin9), 32'(c_ILL9_BIN));
        chk("ill_cnt_pre", 32'(cnt9), 32'd0);
        step();
        chk("ill_cnt_post", 32'(cnt9), 32'd1);

        // backpressure
        ordy9 = 1'b0; v9 = 1'b1; tc9 = 8'h03;
        step();
        chk("bp_ready_1", 32'(rdy9), 32'd1);
        tc9 = 8'h0F;
        step();
        tc9 = 8'h3F;
        chk("bp_ready_full", 32'(rdy9), 32'd0);
        chk("bp_bin_first", 32'(bin9), 32'd2);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_ready", 32'(rdy9), 32'd0);
            chk("bp_hold_bin", 32'(bin9), 32'd2);
            chk("bp_hold_valid", 32'(ov9), 32'd1);
        end
        ordy9 = 1'b1;
        #1;
        chk("bp_release_ready", 32'(rdy9), 32'd1);
        step(); v9 = 1'b0;
        chk("bp_bin_second", 32'(bin9), 32'd4);
        step();
        chk("bp_bin_third", 32'(bin9), 32'd6);
        step();
        chk("bp_drained", 32'(ov9), 32'd0);

        // reset with both stages full
        ordy9 = 1'b0; v9 = 1'b1; tc9 = 8'h01;
        step(); tc9 = 8'h03;
        step(); v9 = 1'b0;
        chk("full_ready", 32'(rdy9), 32'd0);
        chk("full_valid", 32'(ov9), 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(ov9), 32'd0);
        chk("midrst_ready", 32'(rdy9), 32'd0);
        chk("midrst_cnt", 32'(cnt9), 32'd0);
        rst = 1'b0; ordy9 = 1'b1;
        #1;
        chk("midrst_ready_after", 32'(rdy9), 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("midrst_no_stale", 32'(ov9), 32'd0);
        end

        // M=5 instance
        v5 = 1'b1; tc5 = 4'b1111;
        step(); tc5 = 4'b1011;
        step(); v5 = 1'b0;
        chk("m5_bin4", 32'(bin5), 32'd4);
        chk("m5_err4", 32'(err5), 32'd0);
        step();
        chk("m5_ill_err", 32'(err5), 32'd1);
        chk("m5_ill_bin", 32'(bin5), 32'(c_ILL5_BIN));
        step();
        chk("m5_cnt1", 32'(cnt5), 32'd1);

        // saturation with ECW=4
        v5 = 1'b1; tc5 = 4'b0101;
        for (int i = 0; i < 20; i++) step();
        v5 = 1'b0;
        step(); step(); step();
        chk("m5_sat", 32'(cnt5), 32'd15);

        // clear coinciding with an error transfer, then clear alone
        v5 = 1'b1; tc5 = 4'b0101;
        step(); v5 = 1'b0;
        step();
        chk("m5_clr_err_pending", 32'(err5 & ov5), 32'd1);
        clr5 = 1'b1;
        step();
        chk("m5_clr_with_inc", 32'(cnt5), 32'd1);
        step();
        chk("m5_clr_alone", 32'(cnt5), 32'd0);
        clr5 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
